fpu_req_sched: RTL

//  Shares one fixed-latency, non-stallable fpu (out, div_by_zero, ine, overflow, underflow, snan)

---
 rtl/fpu_sched_pkg.sv | 37 +++
 rtl/fpu_sched_fifo.sv | 76 +++++++
 rtl/fpu_req_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared encodings and the result record carried through the FPU request scheduler.
package fpu_sched_pkg;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3,
        FPU_I2F = 3'd4,
        FPU_F2I = 3'd5
    } fpu_op_e;

    typedef enum logic [1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_PINF    = 2'd2,
        RM_NINF    = 2'd3
    } rmode_e;

    // Bit positions inside the 5-bit exception vector {snan,unf,ovf,ine,dbz}.
    localparam int EXC_DBZ  = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_OVF  = 2;
    localparam int EXC_UNF  = 3;
    localparam int EXC_SNAN = 4;
    localparam int EXC_W    = 5;

    // Wide enough for the largest supported requester count (8).
    localparam int ID_W_MAX = 3;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [31:0]         out;
        logic [EXC_W-1:0]    exc;
    } rsp_t;

endpackage

// File: rtl/fpu_sched_fifo.sv
// Synchronous result FIFO with occupancy count; head is presented combinationally.
module fpu_sched_fifo
    import fpu_sched_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  rsp_t          wdata_i,
    input  logic          pop_i,
    output rsp_t          rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Head reads as zero when empty so rsp fields are clean out of reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_i && full_o && !pop_i))
                else $error("fpu_sched_fifo: push into full FIFO");
        end
    end

endmodule

// File: rtl/fpu_req_sched.sv
// Round-robin sharing of one fixed-latency FPU among NREQ requesters, with credit-guarded
// result buffering, id tagging through the FPU pipeline and per-requester sticky flags.
module fpu_req_sched
    import fpu_sched_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  LAT   = 4,
    parameter int  DEPTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*3-1:0]      req_op_i,
    input  logic [NREQ*2-1:0]      req_rmode_i,
    input  logic [NREQ*32-1:0]     req_opa_i,
    input  logic [NREQ*32-1:0]     req_opb_i,
    output logic [2:0]             fpu_op_o,
    output logic [1:0]             fpu_rmode_o,
    output logic [31:0]            fpu_opa_o,
    output logic [31:0]            fpu_opb_o,
    input  logic [31:0]            fpu_out_i,
    input  logic [4:0]             fpu_exc_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [31:0]            rsp_out_o,
    output logic [4:0]             rsp_exc_o,
    output logic [NREQ*5-1:0]      sticky_exc_o,
    input  logic [NREQ-1:0]        sticky_clr_i
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [2:0]  op_arr    [NREQ];
    logic [1:0]  rmode_arr [NREQ];
    logic [31:0] opa_arr   [NREQ];
    logic [31:0] opb_arr   [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi]    = req_op_i[gi*3 +: 3];
        assign rmode_arr[gi] = req_rmode_i[gi*2 +: 2];
        assign opa_arr[gi]   = req_opa_i[gi*32 +: 32];
        assign opb_arr[gi]   = req_opb_i[gi*32 +: 32];
    end

    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [2:0]              fpu_op_q;
    logic [1:0]              fpu_rmode_q;
    logic [31:0]             fpu_opa_q, fpu_opb_q;
    logic [LAT:0]            tag_vld_q;
    logic [LAT:0][IDW-1:0]   tag_id_q;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [NREQ-1:0][4:0]    sticky_q, sticky_d;

    logic [IDW:0]            cand;
    logic                    grant_hit;
    logic [IDW-1:0]          grant_idx;
    logic                    can_issue, accept, push;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty, fifo_full;
    rsp_t                    fifo_wdata, fifo_head;
    logic                    unused_fifo_bits;

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_hit && req_valid_i[cand[IDW-1:0]]) begin
                grant_hit = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    // Every issued op is either still in the tag pipe or sitting in the FIFO, so the sum
    // bounds FIFO occupancy even though the FPU itself can never be stalled.
    assign can_issue   = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
    assign accept      = grant_hit && can_issue;
    assign req_ready_o = (accept && rst_n) ? (NREQ'(1) << grant_idx) : '0;
    assign push        = tag_vld_q[LAT];

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
        outstanding_d = outstanding_q + CW'(accept) - CW'(push);
    end

    always_comb begin
        sticky_d = sticky_q;
        for (int k = 0; k < NREQ; k++) begin
            if (push && (tag_id_q[LAT] == IDW'(k))) begin
                sticky_d[k] = sticky_clr_i[k] ? fpu_exc_i : (sticky_q[k] | fpu_exc_i);
            end else if (sticky_clr_i[k]) begin
                sticky_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            fpu_op_q      <= '0;
            fpu_rmode_q   <= '0;
            fpu_opa_q     <= '0;
            fpu_opb_q     <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            outstanding_q <= '0;
            sticky_q      <= '0;
        end else begin
            ptr_q         <= ptr_d;
            tag_vld_q     <= {tag_vld_q[LAT-1:0], accept};
            tag_id_q      <= {tag_id_q[LAT-1:0], grant_idx};
            outstanding_q <= outstanding_d;
            sticky_q      <= sticky_d;
            if (accept) begin
                fpu_op_q    <= op_arr[grant_idx];
                fpu_rmode_q <= rmode_arr[grant_idx];
                fpu_opa_q   <= opa_arr[grant_idx];
                fpu_opb_q   <= opb_arr[grant_idx];
            end
        end
    end

    assign fifo_wdata = '{id: ID_W_MAX'(tag_id_q[LAT]), out: fpu_out_i, exc: fpu_exc_i};

    fpu_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (rsp_ready_i),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign unused_fifo_bits = fifo_full ^ (^(fifo_head.id >> IDW));

    assign fpu_op_o     = fpu_op_q;
    assign fpu_rmode_o  = fpu_rmode_q;
    assign fpu_opa_o    = fpu_opa_q;
    assign fpu_opb_o    = fpu_opb_q;
    assign rsp_valid_o  = !fifo_empty;
    assign rsp_id_o     = fifo_head.id[IDW-1:0];
    assign rsp_out_o    = fifo_head.out;
    assign rsp_exc_o    = fifo_head.exc;
    assign sticky_exc_o = sticky_q;

endmodule
